// File: rtl/hpt_status_decoder_if.sv
// Status bus between the HPT-axis producer and the receive-side status decoder.
// The producer side drives the status word and clear; the decoder returns registered status.
interface hpt_status_decoder_if #(
  parameter int CYCLE_W = 8,
  parameter int DWELL_W = 16
);
  logic               clear;
  logic [7:0]         status_word;
  logic [2:0]         stage;
  logic [1:0]         body_level;
  logic               stage_change;
  logic [DWELL_W-1:0] dwell;
  logic [CYCLE_W-1:0] cycle_count;
  logic               cycle_done;
  logic               err_transition;
  logic               err_flags;
  logic               err_timeout;
  logic [2:0]         err_code;
  logic [7:0]         err_word;

  modport master (
    output clear, status_word,
    input  stage, body_level, stage_change, dwell, cycle_count, cycle_done,
           err_transition, err_flags, err_timeout, err_code, err_word
  );

  modport slave (
    input  clear, status_word,
    output stage, body_level, stage_change, dwell, cycle_count, cycle_done,
           err_transition, err_flags, err_timeout, err_code, err_word
  );
endinterface

// File: rtl/hpt_status_decoder.sv
// Passive monitor for the HPT-axis status word: decodes, checks transitions/flags, tracks dwell and cycles.
// Optional dwell-timeout check is compiled in with `define HPT_DWELL_TIMEOUT_EN.
module hpt_status_decoder #(
  parameter int CYCLE_W     = 8,
  parameter int DWELL_W     = 16,
  parameter int DWELL_LIMIT = 1000
) (
  input logic                clock,
  input logic                resetn,
  hpt_status_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_NORMAL       = 3'd0,
    ST_TRIGGERED    = 3'd1,
    ST_HYPOTHALAMUS = 3'd2,
    ST_PITUITARY    = 3'd3,
    ST_THYROID      = 3'd4,
    ST_REESTABLISH  = 3'd5,
    ST_AB_STIM      = 3'd6,
    ST_MUTED        = 3'd7
  } stage_e;

  typedef enum logic [1:0] {
    SEEN_NONE = 2'd0,
    SEEN_ONE  = 2'd1,
    SEEN_TWO  = 2'd2
  } seen_e;

  if (DWELL_LIMIT < 1) begin : g_limit_check
    $error("DWELL_LIMIT must be at least 1");
  end

  seen_e              seen_q, seen_d;
  stage_e             stage_q, stage_d, word_stage;
  logic [1:0]         level_q, level_d;
  logic               change_q, change_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic               done_q, done_d;
  logic               err_tr_q, err_tr_d;
  logic               err_fl_q, err_fl_d;
  logic               err_to_q, err_to_d;
  logic [2:0]         code_q, code_d;
  logic [7:0]         eword_q, eword_d;

  logic               legal;
  logic [4:0]         expected_flags;
  logic               tr_err, fl_err, to_err;

  assign word_stage = stage_e'(bus.status_word[7:5]);

  // stage_q doubles as the previous-sample state for both checks
  always_comb begin
    legal = 1'b0;
    unique case (stage_q)
      ST_NORMAL:       legal = word_stage inside {ST_NORMAL, ST_TRIGGERED};
      ST_TRIGGERED:    legal = word_stage inside {ST_TRIGGERED, ST_HYPOTHALAMUS};
      ST_HYPOTHALAMUS: legal = word_stage inside {ST_HYPOTHALAMUS, ST_PITUITARY};
      ST_PITUITARY:    legal = word_stage inside {ST_PITUITARY, ST_THYROID};
      ST_THYROID:      legal = word_stage inside {ST_THYROID, ST_REESTABLISH};
      ST_REESTABLISH:  legal = (word_stage == ST_AB_STIM);
      ST_AB_STIM:      legal = word_stage inside {ST_AB_STIM, ST_MUTED};
      ST_MUTED:        legal = (word_stage == ST_NORMAL);
      default:         legal = 1'b0;
    endcase
  end

  always_comb begin
    expected_flags = '0;
    unique case (stage_q)
      ST_NORMAL:       expected_flags = 5'b00_000;
      ST_TRIGGERED:    expected_flags = 5'b01_000;
      ST_HYPOTHALAMUS: expected_flags = 5'b01_100;
      ST_PITUITARY:    expected_flags = 5'b01_110;
      ST_THYROID:      expected_flags = 5'b01_111;
      ST_REESTABLISH:  expected_flags = 5'b00_001;
      ST_AB_STIM:      expected_flags = 5'b10_001;
      ST_MUTED:        expected_flags = 5'b10_000;
      default:         expected_flags = '0;
    endcase
  end

  always_comb begin
    seen_d   = seen_q;
    stage_d  = stage_q;
    level_d  = level_q;
    change_d = 1'b0;
    done_d   = 1'b0;
    dwell_d  = dwell_q;
    cycle_d  = cycle_q;
    if (bus.clear) begin
      seen_d  = SEEN_NONE;
      stage_d = ST_NORMAL;
      level_d = '0;
      dwell_d = '0;
      cycle_d = '0;
    end else begin
      stage_d  = word_stage;
      level_d  = bus.status_word[4:3];
      seen_d   = (seen_q == SEEN_NONE) ? SEEN_ONE : SEEN_TWO;
      change_d = (seen_q != SEEN_NONE) && (word_stage != stage_q);
      done_d   = (seen_q != SEEN_NONE) && (stage_q == ST_MUTED) && (word_stage == ST_NORMAL);
      if ((seen_q == SEEN_NONE) || change_d)
        dwell_d = DWELL_W'(1);
      else if (dwell_q != '1)
        dwell_d = dwell_q + 1'b1;
      if (done_d)
        cycle_d = cycle_q + 1'b1;
    end
  end

  assign tr_err = !bus.clear && (seen_q != SEEN_NONE) && !legal;
  assign fl_err = !bus.clear && (seen_q == SEEN_TWO) && (bus.status_word[4:0] != expected_flags);

`ifdef HPT_DWELL_TIMEOUT_EN
  localparam logic [DWELL_W-1:0] LIMIT = DWELL_W'(DWELL_LIMIT);
  // Stages 0 and 6 wait on external events, so only 1..4 can time out
  assign to_err = !bus.clear && (dwell_d == LIMIT) &&
                  (word_stage inside {ST_TRIGGERED, ST_HYPOTHALAMUS, ST_PITUITARY, ST_THYROID});
`else
  assign to_err = 1'b0;
`endif

  always_comb begin
    err_tr_d = err_tr_q | tr_err;
    err_fl_d = err_fl_q | fl_err;
    err_to_d = err_to_q | to_err;
    code_d   = code_q;
    eword_d  = eword_q;
    if (bus.clear) begin
      err_tr_d = 1'b0;
      err_fl_d = 1'b0;
      err_to_d = 1'b0;
      code_d   = '0;
      eword_d  = '0;
    end else if ((code_q == '0) && (tr_err || fl_err || to_err)) begin
      code_d  = {to_err, fl_err, tr_err};
      eword_d = bus.status_word;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seen_q   <= SEEN_NONE;
      stage_q  <= ST_NORMAL;
      level_q  <= '0;
      change_q <= 1'b0;
      dwell_q  <= '0;
      cycle_q  <= '0;
      done_q   <= 1'b0;
      err_tr_q <= 1'b0;
      err_fl_q <= 1'b0;
      err_to_q <= 1'b0;
      code_q   <= '0;
      eword_q  <= '0;
    end else begin
      seen_q   <= seen_d;
      stage_q  <= stage_d;
      level_q  <= level_d;
      change_q <= change_d;
      dwell_q  <= dwell_d;
      cycle_q  <= cycle_d;
      done_q   <= done_d;
      err_tr_q <= err_tr_d;
      err_fl_q <= err_fl_d;
      err_to_q <= err_to_d;
      code_q   <= code_d;
      eword_q  <= eword_d;
    end
  end

  assign bus.stage          = stage_q;
  assign bus.body_level     = level_q;
  assign bus.stage_change   = change_q;
  assign bus.dwell          = dwell_q;
  assign bus.cycle_count    = cycle_q;
  assign bus.cycle_done     = done_q;
  assign bus.err_transition = err_tr_q;
  assign bus.err_flags      = err_fl_q;
  assign bus.err_timeout    = err_to_q;
  assign bus.err_code       = code_q;
  assign bus.err_word       = eword_q;

endmodule
